mdc_commutator: RTL
===================

Name: mdc_commutator

Overview:
- Delay-commutator stage of the 32-point radix-2 MDC FFT pipeline.
- Sits directly upstream of each butterfly stage and feeds it.
- Takes two parallel complex lanes (A, B) and reorders them with a DEPTH-sample delay / switch / DEPTH-sample delay network.
- Each output beat presents the two samples that the following butterfly must combine: samples DEPTH apart in the same lane.
- The pipeline is data-driven: all storage advances only on accepted input beats.

Parameters:
- DATA_W, 9: bit width of each real/imag component; matches the butterfly input width.
- DEPTH, 8: delay length and switch period in accepted beats; power of two, minimum 1. The 32-pt stages instantiate 16, 8, 4, 2 and 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat qualifier.
- a_re  input  DATA_W  lane A real, signed.
- a_im  input  DATA_W  lane A imag, signed.
- b_re  input  DATA_W  lane B real, signed.
- b_im  input  DATA_W  lane B imag, signed.
- out_valid  output  1  output beat qualifier, registered.
- c_re  output  DATA_W  output lane C real (later sample of pair).
- c_im  output  DATA_W  output lane C imag.
- d_re  output  DATA_W  output lane D real (earlier sample of pair).
- d_im  output  DATA_W  output lane D imag.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset values: out_valid=0; c/d outputs=0; beat counter=0; fill counter=0; both delay lines cleared to 0.
- Reset mid-frame: discards all in-flight data. The first beat after release is treated as beat k=0.
- Beat counter cnt: log2(DEPTH)+1 bits. Increments on each in_valid, wraps modulo 2*DEPTH.
- Switch select: sel = cnt[MSB], evaluated before the increment. It is 0 for beats 0..DEPTH-1 of each 2*DEPTH period and 1 for the rest.
- Delay line 1 (lane A): aD = A from DEPTH accepted beats earlier.
- Switch:
  - sel=0: s0=aD, s1=B.
  - sel=1: s0=B, s1=aD.
- Delay line 2: sD = s1 from DEPTH accepted beats earlier.
- On a beat with in_valid=1, at the next edge: c <= s0, d <= sD. Both delay lines shift by one.
- in_valid=0: no shift, no counter change. c/d hold their values. out_valid <= 0.
- Fill counter: saturates at DEPTH. out_valid <= in_valid && (fill == DEPTH), using the fill value before the beat. Beats k=0..DEPTH-1 after reset therefore produce out_valid=0.
- Latency: exactly one clk from an accepted beat to its registered output. Pairing delay is DEPTH accepted beats.
- out_valid is high for exactly one cycle per accepted beat; there is no back-pressure.
- Gaps in in_valid are arbitrary: results equal the gap-free stream with idle cycles removed.
- Arithmetic: none. Data pass bit-exact, with no sign extension or rounding.
- DEPTH=1: sel toggles every beat; each delay line is a single register.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=32.
  - Stage DEPTH constants (16, 8, 4, 2, 1).
  - Default DATA_W.
  - A clog2 function.
  - A complex-sample typedef {re, im}.
- One sub-module: delay_line. Parameterised DEPTH and WIDTH, enable-gated shift register with synchronous active-low clear. It is instantiated twice, each on the packed {re, im} of its lane.

Test Plan:
- Test 1, basic pairing: DEPTH=2; continuous in_valid; a_re=k+1, b_re=100+k, imag=-re.
  - Expected: out_valid low for beats 0-1.
  - Then (c_re,d_re) = (102,100), (103,101), (3,1), (4,2), (106,104), (107,105).
  - Imag components match the negated reals.
- Test 2, gapped input: same stream as Test 1 with in_valid deasserted on random cycles (about 50%).
  - Expected: identical sequence of valid outputs; c/d hold and out_valid=0 during gaps.
- Test 3, mid-frame reset: rst_n low for one cycle after beat 5, then restart the stream at k=0.
  - Expected: out_valid=0 and c/d=0 the cycle after reset.
  - The Test 1 sequence then repeats with no stale data.
- Test 4, DEPTH=1: a_re=k, b_re=50+k.
  - Expected: out_valid from beat 1; pairs (51,50), (1,0), (53,52), (3,2).
- Test 5, extremes: DEPTH=16; DATA_W=9; values -256 and +255 in both lanes.
  - Expected: bit-exact passthrough at the paired positions, with first out_valid on beat 16.
- Test 6, reference-model check: random data for 200 beats at DEPTH=8.
  - Expected: the model c[k]/d[k] match for every out_valid beat.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point radix-2 MDC FFT pipeline.
// Provides the transform size, the per-stage commutator depths, the default
// sample component width, a ceiling-log2 helper and a complex-sample type.
package fft_pkg;

    localparam int FFT_N         = 32;
    localparam int DATA_W_DEF    = 9;

    // Commutator depths for stages 0..4 of the 32-point pipeline.
    localparam int STAGE0_DEPTH  = 16;
    localparam int STAGE1_DEPTH  = 8;
    localparam int STAGE2_DEPTH  = 4;
    localparam int STAGE3_DEPTH  = 2;
    localparam int STAGE4_DEPTH  = 1;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdc_commutator_delay_line.sv
// Enable-gated shift register of DEPTH words, each WIDTH bits wide.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low clear of every stage
//   en    - shift enable; storage holds when low
//   din   - word shifted into stage 0
//   dout  - word that entered DEPTH enabled cycles ago
module delay_line #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    import fft_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/mdc_commutator.sv
// Delay-commutator stage of the radix-2 MDC FFT. Reorders two complex lanes
// so each output beat carries the pair of same-lane samples DEPTH beats apart
// that the following butterfly combines. All storage advances only on
// accepted (in_valid) beats.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid              - input beat qualifier
//   a_re/a_im, b_re/b_im  - input lanes A and B (signed)
//   out_valid             - registered output beat qualifier
//   c_re/c_im             - later sample of the pair
//   d_re/d_im             - earlier sample of the pair
module mdc_commutator
    import fft_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    output logic              out_valid,
    output logic [DATA_W-1:0] c_re,
    output logic [DATA_W-1:0] c_im,
    output logic [DATA_W-1:0] d_re,
    output logic [DATA_W-1:0] d_im
);

    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int PK_W  = 2 * DATA_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             out_valid_q, out_valid_d;
    logic [PK_W-1:0]  c_q, c_d;
    logic [PK_W-1:0]  d_q, d_d;

    logic [PK_W-1:0]  a_pk, b_pk, a_dly, s0, s1, s_dly;
    logic             sel;

    assign a_pk = {a_re, a_im};
    assign b_pk = {b_re, b_im};

    // Counter width makes the wrap at 2*DEPTH implicit; MSB is the switch phase.
    assign sel = cnt_q[CNT_W-1];
    assign s0  = sel ? b_pk  : a_dly;
    assign s1  = sel ? a_dly : b_pk;

    delay_line #(.DEPTH(DEPTH), .WIDTH(PK_W)) u_dly_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (a_pk),
        .dout  (a_dly)
    );

    delay_line #(.DEPTH(DEPTH), .WIDTH(PK_W)) u_dly_s (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (s1),
        .dout  (s_dly)
    );

    always_comb begin
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            cnt_d       = cnt_q + CNT_W'(1);
            c_d         = s0;
            d_d         = s_dly;
            // Outputs are meaningful only once the second delay line is primed.
            out_valid_d = (fill_q == CNT_W'(DEPTH));
            if (fill_q != CNT_W'(DEPTH)) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            d_q         <= '0;
        end else begin
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            d_q         <= d_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c_re      = c_q[PK_W-1:DATA_W];
    assign c_im      = c_q[DATA_W-1:0];
    assign d_re      = d_q[PK_W-1:DATA_W];
    assign d_im      = d_q[DATA_W-1:0];

endmodule
